// File: rtl/eth_out_arb.sv
// eth_out_arb: per-egress-port packet scheduler, round-robin over two ingress FIFOs with peer locking
module eth_out_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_CNT_W  = 16,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [1:0]            qEmpty,
  input  logic [DATA_WIDTH+1:0] qData0,
  input  logic [DATA_WIDTH+1:0] qData1,
  input  logic [1:0]            qDest,
  output logic [1:0]            qRdEn,
  input  logic [1:0]            peerLock,
  output logic [1:0]            ownLock,
  input  logic                  outStall,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outSop,
  output logic                  outEop,
  output logic [PKT_CNT_W-1:0]  pktCnt0,
  output logic [PKT_CNT_W-1:0]  pktCnt1,
  output logic [ERR_CNT_W-1:0]  errCnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
  localparam int SOP = DATA_WIDTH;
  localparam int EOP = DATA_WIDTH + 1;

  logic [0:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  rr_q, rr_d;
  logic [1:0]            own_q, own_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic [PKT_CNT_W-1:0]  pc0_q, pc0_d, pc1_q, pc1_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;

  logic [1:0]            sops, elig, orph, rd;
  logic                  gsel, hsel, take, term, err_inc;
  logic [DATA_WIDTH+1:0] word;

  assign sops = {qData1[SOP], qData0[SOP]};
  assign elig = ~qEmpty & sops & qDest & ~peerLock;
  assign orph = ~qEmpty & ~sops & ~peerLock;
  assign gsel = &elig ? rr_q : elig[1];
  assign hsel = state_q == XFER ? grant_q : gsel;
  assign word = hsel ? qData1 : qData0;

  // Decide this cycle's pop (grant, continuation, orphan drop or terminator) and the next register values
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    own_d   = own_q;
    valid_d = 1'b0;
    data_d  = data_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    rd      = 2'b00;
    take    = 1'b0;
    term    = 1'b0;
    err_inc = 1'b0;
    if (state_q == IDLE) begin
      if (!outStall && |elig) begin
        take = 1'b1;
      end else if (|orph) begin
        rd      = orph[0] ? 2'b01 : 2'b10;
        err_inc = 1'b1;
      end
    end else if (!qEmpty[grant_q] && !peerLock[grant_q] && !outStall) begin
      term = word[SOP];
      take = !word[SOP];
    end
    if (take) begin
      rd      = hsel ? 2'b10 : 2'b01;
      valid_d = 1'b1;
      data_d  = word[DATA_WIDTH-1:0];
      sop_d   = word[SOP];
      eop_d   = word[EOP];
      grant_d = hsel;
      state_d = word[EOP] ? IDLE : XFER;
      own_d   = word[EOP] ? 2'b00 : (hsel ? 2'b10 : 2'b01);
      rr_d    = word[EOP] ? ~hsel : rr_q;
      pc0_d   = pc0_q + PKT_CNT_W'(word[EOP] && !hsel);
      pc1_d   = pc1_q + PKT_CNT_W'(word[EOP] && hsel);
    end
    if (term) begin
      valid_d = 1'b1;
      eop_d   = 1'b1;
      data_d  = '0;
      state_d = IDLE;
      own_d   = 2'b00;
      rr_d    = ~grant_q;
      err_inc = 1'b1;
    end
    err_d = (err_inc && !(&err_q)) ? err_q + ERR_CNT_W'(1) : err_q;
  end

  // State, egress registers and counters; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
      own_q   <= 2'b00;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      err_q   <= err_d;
    end
  end

  assign qRdEn    = resetN ? rd : 2'b00;
  assign ownLock  = own_q;
  assign outValid = valid_q;
  assign outData  = data_q;
  assign outSop   = sop_q;
  assign outEop   = eop_q;
  assign pktCnt0  = pc0_q;
  assign pktCnt1  = pc1_q;
  assign errCnt   = err_q;
endmodule

// File: tb/tb_eth_out_arb.sv
// tb_eth_out_arb: directed and randomized checks of eth_out_arb against FIFO and packet-order models
module tb_eth_out_arb;
  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  qEmpty, qDest, qRdEn, peerLock, ownLock, gate;
  logic [33:0] qData0, qData1;
  logic        outStall, outValid, outSop, outEop;
  logic [31:0] outData;
  logic [15:0] pktCnt0, pktCnt1;
  logic [7:0]  errCnt;

  logic [34:0] q0[$], q1[$];
  logic [33:0] eg[$], expq[$], e0[$], e1[$], o0[$], o1[$];
  logic [1:0]  rd;
  int total, bad;

  eth_out_arb dut (
    .clk(clk), .resetN(resetN), .qEmpty(qEmpty), .qData0(qData0), .qData1(qData1),
    .qDest(qDest), .qRdEn(qRdEn), .peerLock(peerLock), .ownLock(ownLock),
    .outStall(outStall), .outValid(outValid), .outData(outData), .outSop(outSop),
    .outEop(outEop), .pktCnt0(pktCnt0), .pktCnt1(pktCnt1), .errCnt(errCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_heads();
    qEmpty[0] = gate[0] || q0.size() == 0;
    qEmpty[1] = gate[1] || q1.size() == 0;
    qData0    = q0.size() != 0 ? q0[0][33:0] : '0;
    qData1    = q1.size() != 0 ? q1[0][33:0] : '0;
    qDest[0]  = q0.size() != 0 ? q0[0][34] : 1'b0;
    qDest[1]  = q1.size() != 0 ? q1[0][34] : 1'b0;
  endtask

  task automatic step();
    drive_heads();
    @(negedge clk);
    rd = qRdEn;
    chk("rd_legal", 64'(rd & (qEmpty | peerLock)), 64'd0);
    @(posedge clk);
    #1;
    if (rd[0]) void'(q0.pop_front());
    if (rd[1]) void'(q1.pop_front());
    if (outValid) eg.push_back({outEop, outSop, outData});
  endtask

  task automatic push_word(input int qi, input logic [34:0] w);
    if (qi == 0) q0.push_back(w);
    else q1.push_back(w);
  endtask

  task automatic push_pkt(input int qi, input int n, input bit dest, input logic [31:0] base, input bit noeop);
    for (int k = 0; k < n; k++)
      push_word(qi, {dest, !noeop && k == n - 1, k == 0, 32'(base + k)});
  endtask

  task automatic add_exp(input int n, input logic [31:0] base, input bit noeop);
    for (int k = 0; k < n; k++)
      expq.push_back({!noeop && k == n - 1, k == 0, 32'(base + k)});
  endtask

  task automatic cmp_eg(input string tag);
    chk({tag, "_len"}, 64'(eg.size()), 64'(expq.size()));
    for (int k = 0; k < eg.size() && k < expq.size(); k++)
      chk({tag, "_word"}, 64'(eg[k]), 64'(expq[k]));
    eg.delete();
    expq.delete();
  endtask

  initial begin
    int t2[8];
    int t3r[9];
    int t4r[9];
    int t5r[6];
    int npk0, npk1, guard;
    bit inpkt;
    logic [3:0] curtag, tag;
    total = 0;
    bad = 0;
    resetN = 1'b0;
    outStall = 1'b0;
    peerLock = 2'b00;
    gate = 2'b00;
    push_pkt(0, 4, 1, 32'h0000ABCD, 0);
    repeat (3) begin
      step();
      chk("rst_rd", 64'(rd), 64'd0);
    end
    chk("rst_out", 64'({outValid, outSop, outEop, outData}), 64'd0);
    chk("rst_cnt", 64'({ownLock, pktCnt0, pktCnt1, errCnt}), 64'd0);
    resetN = 1'b1;
    eg.delete();

    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_rd", 64'(rd), 64'd1);
      chk("t1_out", 64'({outValid, outSop, outEop, outData}), 64'({1'b1, k == 0, k == 3, 32'(32'hABCD + k)}));
      chk("t1_lock", 64'(ownLock), k < 3 ? 64'd1 : 64'd0);
    end
    chk("t1_pkt", 64'(pktCnt0), 64'd1);
    step();
    chk("t1_idle", 64'({rd, outValid}), 64'd0);

    resetN = 1'b0;
    step();
    resetN = 1'b1;
    eg.delete();
    chk("t2_rst", 64'({pktCnt0, pktCnt1}), 64'd0);
    push_pkt(0, 2, 1, 32'h100, 0);
    push_pkt(0, 2, 1, 32'h200, 0);
    push_pkt(1, 2, 1, 32'h1100, 0);
    push_pkt(1, 2, 1, 32'h1200, 0);
    add_exp(2, 32'h100, 0);
    add_exp(2, 32'h1100, 0);
    add_exp(2, 32'h200, 0);
    add_exp(2, 32'h1200, 0);
    t2 = '{1, 1, 2, 2, 1, 1, 2, 2};
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_rd", 64'(rd), 64'(t2[i]));
      if (i == 5) chk("t2_cnt", 64'({pktCnt0, pktCnt1}), 64'({16'd2, 16'd1}));
    end
    chk("t2_cnt_end", 64'({pktCnt0, pktCnt1}), 64'({16'd2, 16'd2}));
    step();
    cmp_eg("t2_eg");

    push_pkt(0, 6, 1, 32'h300, 0);
    add_exp(6, 32'h300, 0);
    t3r = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      outStall = i >= 2 && i <= 4;
      step();
      chk("t3_rd", 64'(rd), 64'(t3r[i]));
      chk("t3_valid", 64'(outValid), 64'(t3r[i] != 0));
    end
    outStall = 1'b0;
    step();
    chk("t3_pkt", 64'(pktCnt0), 64'd3);
    cmp_eg("t3_eg");

    push_pkt(0, 6, 1, 32'h400, 0);
    add_exp(6, 32'h400, 0);
    add_exp(2, 32'h1400, 0);
    step();
    chk("t4_first", 64'(rd), 64'd1);
    push_pkt(1, 2, 1, 32'h1400, 0);
    t4r = '{1, 0, 0, 1, 1, 1, 1, 2, 2};
    for (int i = 0; i < 9; i++) begin
      gate = (i == 1 || i == 2) ? 2'b01 : 2'b00;
      step();
      chk("t4_rd", 64'(rd), 64'(t4r[i]));
      chk("t4_valid", 64'(outValid), 64'(t4r[i] != 0));
      if (i < 6) chk("t4_lock", 64'(ownLock), 64'd1);
    end
    gate = 2'b00;
    step();
    chk("t4_cnt", 64'({pktCnt0, pktCnt1}), 64'({16'd4, 16'd3}));
    cmp_eg("t4_eg");

    push_pkt(0, 3, 1, 32'h500, 1);
    push_pkt(0, 2, 1, 32'h600, 0);
    add_exp(3, 32'h500, 1);
    expq.push_back({1'b1, 1'b0, 32'h0});
    add_exp(2, 32'h600, 0);
    t5r = '{1, 1, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_rd", 64'(rd), 64'(t5r[i]));
      if (i == 3) begin
        chk("t5_term", 64'({outValid, outSop, outEop, outData}), 64'({1'b1, 1'b0, 1'b1, 32'h0}));
        chk("t5_err", 64'({ownLock, errCnt}), 64'({2'b00, 8'd1}));
        chk("t5_nocnt", 64'(pktCnt0), 64'd4);
      end
    end
    step();
    chk("t5_pkt", 64'(pktCnt0), 64'd5);
    cmp_eg("t5_eg");

    push_pkt(1, 2, 1, 32'h1700, 0);
    add_exp(2, 32'h1700, 0);
    peerLock = 2'b10;
    repeat (2) begin
      step();
      chk("t6_locked", 64'(rd), 64'd0);
    end
    peerLock = 2'b00;
    repeat (2) begin
      step();
      chk("t6_unlock", 64'(rd), 64'd2);
    end
    chk("t6_pkt", 64'(pktCnt1), 64'd4);
    push_word(1, {1'b0, 1'b0, 1'b0, 32'h1800});
    step();
    chk("t6_orph_rd", 64'(rd), 64'd2);
    chk("t6_orph_out", 64'({outValid, errCnt}), 64'({1'b0, 8'd2}));
    push_word(1, {1'b0, 1'b0, 1'b0, 32'h1801});
    peerLock = 2'b10;
    step();
    chk("t6_orph_lock", 64'(rd), 64'd0);
    peerLock = 2'b00;
    step();
    chk("t6_orph_rd2", 64'({rd, errCnt}), 64'({2'd2, 8'd3}));
    push_word(0, {1'b0, 1'b0, 1'b0, 32'h880});
    push_word(1, {1'b0, 1'b0, 1'b0, 32'h1880});
    step();
    chk("t6_orph_pri0", 64'(rd), 64'd1);
    step();
    chk("t6_orph_pri1", 64'({rd, errCnt}), 64'({2'd2, 8'd5}));
    push_pkt(0, 2, 0, 32'h900, 0);
    step();
    chk("t6_nodest", 64'(rd), 64'd0);
    push_pkt(1, 2, 1, 32'h1900, 0);
    add_exp(2, 32'h1900, 0);
    repeat (2) begin
      step();
      chk("t6_other", 64'(rd), 64'd2);
    end
    q0.delete();
    step();
    chk("t6_idle", 64'({rd, errCnt}), 64'({2'd0, 8'd5}));
    cmp_eg("t6_eg");

    for (int i = 0; i < 260; i++) push_word(1, {1'b0, 1'b0, 1'b0, 32'(i)});
    repeat (265) step();
    chk("sat_err", 64'(errCnt), 64'd255);
    chk("sat_noout", 64'(eg.size()), 64'd0);

    resetN = 1'b0;
    q0.delete();
    q1.delete();
    step();
    resetN = 1'b1;
    eg.delete();
    npk0 = 0;
    npk1 = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0 && q0.size() < 20) begin
        int n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) e0.push_back({k == n - 1, k == 0, 4'd1, 12'(npk0), 16'(k)});
        push_pkt(0, n, 1, {4'd1, 12'(npk0), 16'd0}, 0);
        npk0++;
      end
      if ($urandom_range(0, 9) == 0 && q1.size() < 20) begin
        int n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) e1.push_back({k == n - 1, k == 0, 4'd2, 12'(npk1), 16'(k)});
        push_pkt(1, n, 1, {4'd2, 12'(npk1), 16'd0}, 0);
        npk1++;
      end
      outStall = $urandom_range(0, 4) == 0;
      gate[0] = $urandom_range(0, 7) == 0;
      gate[1] = $urandom_range(0, 7) == 0;
      peerLock[0] = !ownLock[0] && $urandom_range(0, 5) == 0;
      peerLock[1] = !ownLock[1] && $urandom_range(0, 5) == 0;
      step();
    end
    outStall = 1'b0;
    gate = 2'b00;
    peerLock = 2'b00;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0 || ownLock != 2'b00) && guard < 500) begin
      step();
      guard++;
    end
    chk("r_drain", 64'(guard < 500), 64'd1);
    repeat (2) step();
    inpkt = 1'b0;
    curtag = 4'd0;
    foreach (eg[k]) begin
      tag = eg[k][31:28];
      if (eg[k][32]) begin
        chk("r_contig", 64'(inpkt), 64'd0);
        curtag = tag;
        inpkt = 1'b1;
      end else begin
        chk("r_inpkt", 64'(inpkt), 64'd1);
        chk("r_tag", 64'(tag), 64'(curtag));
      end
      if (tag == 4'd1) o0.push_back(eg[k]);
      else o1.push_back(eg[k]);
      if (eg[k][33]) inpkt = 1'b0;
    end
    chk("r_len0", 64'(o0.size()), 64'(e0.size()));
    chk("r_len1", 64'(o1.size()), 64'(e1.size()));
    for (int k = 0; k < o0.size() && k < e0.size(); k++) chk("r_q0", 64'(o0[k]), 64'(e0[k]));
    for (int k = 0; k < o1.size() && k < e1.size(); k++) chk("r_q1", 64'(o1[k]), 64'(e1[k]));
    chk("r_cnt", 64'({pktCnt0, pktCnt1}), 64'({16'(npk0), 16'(npk1)}));
    chk("r_err", 64'(errCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
